// File: rtl/host_uart_pkg.sv
// Shared types and constants for the host-side UART link.
// Optional even-parity framing is enabled by defining UART_PARITY_EN.
package host_uart_pkg;

   localparam int unsigned DEF_CLK_PER_BIT = 868;
   localparam int unsigned DATA_BITS       = 8;
`ifdef UART_PARITY_EN
   localparam int unsigned FRAME_BITS      = 11;
`else
   localparam int unsigned FRAME_BITS      = 10;
`endif

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_STOP   = 3'd3,
      TX_PARITY = 3'd4
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_STOP      = 3'd3,
      RX_WAIT_HIGH = 3'd4,
      RX_PARITY    = 3'd5
   } rx_state_e;

   // Even parity: XOR of all data bits.
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/host_uart_link_if.sv
// Host-facing byte interface of the UART link: tx handshake and rx pulses.
interface host_uart_link_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, rx_data, rx_valid, rx_frame_err
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, rx_data, rx_valid, rx_frame_err
   );
endinterface

// File: rtl/host_uart_rx.sv
// UART receiver: rxd synchronizer plus mid-bit sampling receive FSM.
// With UART_PARITY_EN an even-parity bit is checked before the stop bit.
module host_uart_rx
   import host_uart_pkg::*;
#(
   parameter int unsigned CLK_PER_BIT = DEF_CLK_PER_BIT,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_frame_err
);

   localparam int unsigned BAUD_W = $clog2(CLK_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLK_PER_BIT / 2);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   rx_state_e              state_q, state_d;
   logic [BAUD_W-1:0]      baud_q, baud_d;
   logic [2:0]             bit_q, bit_d;
   logic [7:0]             shift_q, shift_d;
   logic [7:0]             rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   rx_err_q, rx_err_d;
   logic                   rxd_s;
   logic                   baud_done;
   logic                   par_ok;

   assign rxd_s     = sync_q[SYNC_STAGES-1];
   assign baud_done = (baud_q == BAUD_LAST);

`ifdef UART_PARITY_EN
   logic par_q, par_d;
   assign par_ok = (par_q == even_parity(shift_q));
`else
   assign par_ok = 1'b1;
`endif

   // Synchronizer shift, oldest sample at the top.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], rxd};
   end

   // Receive FSM next-state and outputs.
   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_err_d   = 1'b0;
`ifdef UART_PARITY_EN
      par_d      = par_q;
`endif
      case (state_q)
         RX_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (!rxd_s) state_d = RX_START;
         end
         RX_START: begin
            baud_d = baud_q + BAUD_W'(1);
            if (baud_q == BAUD_HALF) begin
               baud_d  = '0;
               state_d = rxd_s ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            baud_d = baud_q + BAUD_W'(1);
            if (baud_done) begin
               baud_d         = '0;
               shift_d[bit_q] = rxd_s;
               bit_d          = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_d = RX_PARITY;
`else
                  state_d = RX_STOP;
`endif
               end
            end
         end
`ifdef UART_PARITY_EN
         RX_PARITY: begin
            baud_d = baud_q + BAUD_W'(1);
            if (baud_done) begin
               baud_d  = '0;
               par_d   = rxd_s;
               state_d = RX_STOP;
            end
         end
`endif
         RX_STOP: begin
            baud_d = baud_q + BAUD_W'(1);
            if (baud_done) begin
               baud_d = '0;
               if (!rxd_s) begin
                  rx_err_d = 1'b1;
                  state_d  = RX_WAIT_HIGH;
               end else begin
                  state_d = RX_IDLE;
                  if (par_ok) begin
                     rx_data_d  = shift_q;
                     rx_valid_d = 1'b1;
                  end else begin
                     rx_err_d = 1'b1;
                  end
               end
            end
         end
         RX_WAIT_HIGH: begin
            baud_d = '0;
            if (rxd_s) state_d = RX_IDLE;
         end
         default: state_d = RX_IDLE;
      endcase
   end

   // Receive state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q     <= '1;
         state_q    <= RX_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
`ifdef UART_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         sync_q     <= sync_d;
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_err_q   <= rx_err_d;
`ifdef UART_PARITY_EN
         par_q      <= par_d;
`endif
      end
   end

   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign rx_frame_err = rx_err_q;

endmodule

// File: rtl/host_uart_link.sv
// Host-side full-duplex UART endpoint: inline transmitter plus host_uart_rx.
// Define UART_PARITY_EN to add an even-parity bit (11-bit frames).
module host_uart_link
   import host_uart_pkg::*;
#(
   parameter int unsigned CLK_PER_BIT = DEF_CLK_PER_BIT,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            txd,
   input  logic            rxd,
   host_uart_link_if.slave bus
);

   localparam int unsigned BAUD_W = $clog2(CLK_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);

   tx_state_e         state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        data_q, data_d;
   logic              txd_q, txd_d;
   logic              tx_ready_q, tx_ready_d;
   logic              baud_done;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_frame_err;

   assign baud_done = (baud_q == BAUD_LAST);

   // Transmit FSM next-state; txd is registered so each level lasts whole bit times.
   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      data_d     = data_q;
      txd_d      = txd_q;
      tx_ready_d = tx_ready_q;
      case (state_q)
         TX_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (bus.tx_valid && tx_ready_q) begin
               data_d     = bus.tx_data;
               state_d    = TX_START;
               txd_d      = 1'b0;
               tx_ready_d = 1'b0;
            end
         end
         TX_START: begin
            baud_d = baud_q + BAUD_W'(1);
            if (baud_done) begin
               baud_d  = '0;
               state_d = TX_DATA;
               txd_d   = data_q[0];
            end
         end
         TX_DATA: begin
            baud_d = baud_q + BAUD_W'(1);
            if (baud_done) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_d = TX_PARITY;
                  txd_d   = even_parity(data_q);
`else
                  state_d = TX_STOP;
                  txd_d   = 1'b1;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
                  txd_d = data_q[3'(bit_q + 3'd1)];
               end
            end
         end
`ifdef UART_PARITY_EN
         TX_PARITY: begin
            baud_d = baud_q + BAUD_W'(1);
            if (baud_done) begin
               baud_d  = '0;
               state_d = TX_STOP;
               txd_d   = 1'b1;
            end
         end
`endif
         TX_STOP: begin
            baud_d = baud_q + BAUD_W'(1);
            if (baud_done) begin
               baud_d     = '0;
               state_d    = TX_IDLE;
               txd_d      = 1'b1;
               tx_ready_d = 1'b1;
            end
         end
         default: begin
            state_d    = TX_IDLE;
            txd_d      = 1'b1;
            tx_ready_d = 1'b1;
         end
      endcase
   end

   // Transmit state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= TX_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         data_q     <= '0;
         txd_q      <= 1'b1;
         tx_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         data_q     <= data_d;
         txd_q      <= txd_d;
         tx_ready_q <= tx_ready_d;
      end
   end

   host_uart_rx #(
      .CLK_PER_BIT (CLK_PER_BIT),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_rx (
      .clk          (clk),
      .rst          (rst),
      .rxd          (rxd),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_frame_err (rx_frame_err)
   );

   assign txd              = txd_q;
   assign bus.tx_ready     = tx_ready_q;
   assign bus.rx_data      = rx_data;
   assign bus.rx_valid     = rx_valid;
   assign bus.rx_frame_err = rx_frame_err;

endmodule

// File: tb/tb_host_uart_link.sv
// Directed bench for host_uart_link at 16 clocks per bit.
module tb_host_uart_link;
   import host_uart_pkg::*;

   localparam int CPB       = 16;
   localparam int FRAME_CYC = int'(FRAME_BITS) * CPB;

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;   // line level per bit slot, slot 0 = start bit
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic txd;
   logic loop_en;
   logic rxd_drv;
   logic rxd_w;

   int n_vec   = 0;
   int n_fail  = 0;
   int err_cnt = 0;
   logic [7:0] rxq[$];
   vec_t vecs[9];

   host_uart_link_if bus_if();

   assign rxd_w = loop_en ? txd : rxd_drv;

   host_uart_link #(.CLK_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
      .clk (clk),
      .rst (rst),
      .txd (txd),
      .rxd (rxd_w),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Record every receive pulse.
   always @(negedge clk) begin
      if (bus_if.rx_valid === 1'b1) rxq.push_back(bus_if.rx_data);
      if (bus_if.rx_frame_err === 1'b1) err_cnt++;
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic exp_slot(input vec_t v, input int s);
`ifdef UART_PARITY_EN
      if (s == 9)  return ^v.data;
      if (s == 10) return 1'b1;
`endif
      return v.frame[s];
   endfunction

   task automatic wait_ready();
      int i;
      for (i = 0; i < 2000; i++) begin
         if (bus_if.tx_ready === 1'b1) break;
         @(negedge clk);
      end
      if (i == 2000) chk("tx_ready_timeout", 16'(bus_if.tx_ready), 16'd1);
   endtask

   // Check txd every cycle of one frame, starting at the negedge after the handshake.
   task automatic watch_frame(input vec_t v, input string tag);
      for (int c = 0; c < FRAME_CYC; c++) begin
         if (c > 0) @(negedge clk);
         chk($sformatf("%s_txd_c%0d", tag, c), 16'(txd), 16'(exp_slot(v, c / CPB)));
      end
      chk({tag, "_busy_last"}, 16'(bus_if.tx_ready), 16'd0);
      @(negedge clk);
      chk({tag, "_ready_back"}, 16'(bus_if.tx_ready), 16'd1);
   endtask

   task automatic send_byte(input vec_t v, input string tag);
      wait_ready();
      bus_if.tx_data  = v.data;
      bus_if.tx_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_if.tx_valid = 1'b0;
      bus_if.tx_data  = ~v.data;
      watch_frame(v, tag);
   endtask

   // Bit-bang one frame onto rxd; a low stop bit is held for extra cycles.
   task automatic drive_rx(input logic [7:0] d, input logic stop, input int extra);
      rxd_drv = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd_drv = d[i];
         repeat (CPB) @(negedge clk);
      end
`ifdef UART_PARITY_EN
      rxd_drv = ^d;
      repeat (CPB) @(negedge clk);
`endif
      rxd_drv = stop;
      repeat (CPB + (stop ? 0 : extra)) @(negedge clk);
      rxd_drv = 1'b1;
   endtask

   initial begin
      int   err0;
      vec_t v2;

      vecs[0] = '{8'hA5, 10'b1_10100101_0};
      vecs[1] = '{8'h0F, 10'b1_00001111_0};
      vecs[2] = '{8'h1E, 10'b1_00011110_0};
      vecs[3] = '{8'h3C, 10'b1_00111100_0};
      vecs[4] = '{8'h55, 10'b1_01010101_0};
      vecs[5] = '{8'h00, 10'b1_00000000_0};
      vecs[6] = '{8'hFF, 10'b1_11111111_0};
      vecs[7] = '{8'h80, 10'b1_10000000_0};
      vecs[8] = '{8'h01, 10'b1_00000001_0};

      rst = 1'b1; loop_en = 1'b1; rxd_drv = 1'b1;
      bus_if.tx_valid = 1'b0; bus_if.tx_data = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_txd", 16'(txd), 16'd1);
      chk("rst_tx_ready", 16'(bus_if.tx_ready), 16'd1);
      chk("rst_rx_data", 16'(bus_if.rx_data), 16'h00);
      chk("rst_rx_valid", 16'(bus_if.rx_valid), 16'd0);
      chk("rst_rx_frame_err", 16'(bus_if.rx_frame_err), 16'd0);
      rst = 1'b0;

      // Idle line after reset.
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk("idle_txd", 16'(txd), 16'd1);
         chk("idle_tx_ready", 16'(bus_if.tx_ready), 16'd1);
      end
      chk("idle_no_rx", 16'(rxq.size()), 16'd0);
      chk("idle_no_err", 16'(err_cnt), 16'd0);

      // Table: transmit each byte, loop back, compare line levels and received byte.
      for (int k = 0; k < 9; k++) begin
         send_byte(vecs[k], $sformatf("vec%0d", k));
         repeat (8) @(negedge clk);
         chk($sformatf("vec%0d_rx_count", k), 16'(rxq.size()), 16'd1);
         if (rxq.size() > 0) chk($sformatf("vec%0d_rx_byte", k), 16'(rxq[0]), 16'(vecs[k].data));
         chk($sformatf("vec%0d_rx_hold", k), 16'(bus_if.rx_data), 16'(vecs[k].data));
         rxq.delete();
      end
      chk("loop_no_err", 16'(err_cnt), 16'd0);

      // Back-to-back 0x0F then 0x1E with tx_valid held across the boundary.
      wait_ready();
      bus_if.tx_data = 8'h0F; bus_if.tx_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_if.tx_data = 8'h1E;
      watch_frame(vecs[1], "b2b0");
      @(posedge clk);
      @(negedge clk);
      bus_if.tx_valid = 1'b0; bus_if.tx_data = 8'h00;
      watch_frame(vecs[2], "b2b1");
      repeat (8) @(negedge clk);
      chk("b2b_rx_count", 16'(rxq.size()), 16'd2);
      if (rxq.size() == 2) begin
         chk("b2b_rx0", 16'(rxq[0]), 16'h0F);
         chk("b2b_rx1", 16'(rxq[1]), 16'h1E);
      end
      chk("b2b_no_err", 16'(err_cnt), 16'd0);
      rxq.delete();

      // Short low glitch must be rejected, then a clean 0x3C frame is received.
      loop_en = 1'b0; rxd_drv = 1'b1;
      repeat (4) @(negedge clk);
      rxd_drv = 1'b0;
      repeat (4) @(negedge clk);
      rxd_drv = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch_no_rx", 16'(rxq.size()), 16'd0);
      chk("glitch_no_err", 16'(err_cnt), 16'd0);
      drive_rx(8'h3C, 1'b1, 0);
      repeat (20) @(negedge clk);
      chk("after_glitch_count", 16'(rxq.size()), 16'd1);
      if (rxq.size() > 0) chk("after_glitch_byte", 16'(rxq[0]), 16'h3C);
      rxq.delete();

      // 0x55 with a low stop bit and a trailing break: one error pulse only.
      err0 = err_cnt;
      drive_rx(8'h55, 1'b0, 50);
      repeat (30) @(negedge clk);
      chk("ferr_pulses", 16'(err_cnt - err0), 16'd1);
      chk("ferr_no_rx", 16'(rxq.size()), 16'd0);
      chk("ferr_rx_data_kept", 16'(bus_if.rx_data), 16'h3C);
      drive_rx(8'h55, 1'b1, 0);
      repeat (20) @(negedge clk);
      chk("ferr_recover_count", 16'(rxq.size()), 16'd1);
      if (rxq.size() > 0) chk("ferr_recover_byte", 16'(rxq[0]), 16'h55);
      chk("ferr_recover_no_err", 16'(err_cnt - err0), 16'd1);
      rxq.delete();

      // Reset during data bit 3 of a looped-back transmit.
      loop_en = 1'b1;
      err0 = err_cnt;
      wait_ready();
      bus_if.tx_data = 8'hC3; bus_if.tx_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_if.tx_valid = 1'b0;
      repeat (72) @(negedge clk);
      chk("rst_mid_bit3", 16'(txd), 16'd0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid_txd", 16'(txd), 16'd1);
      chk("rst_mid_tx_ready", 16'(bus_if.tx_ready), 16'd1);
      chk("rst_mid_rx_data", 16'(bus_if.rx_data), 16'h00);
      rst = 1'b0;
      repeat (200) @(negedge clk);
      chk("rst_mid_no_rx", 16'(rxq.size()), 16'd0);
      chk("rst_mid_no_err", 16'(err_cnt - err0), 16'd0);
      v2 = vecs[0];
      send_byte(v2, "post_rst");
      repeat (8) @(negedge clk);
      chk("post_rst_rx_count", 16'(rxq.size()), 16'd1);
      if (rxq.size() > 0) chk("post_rst_rx_byte", 16'(rxq[0]), 16'hA5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
